// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
package pipe_ctrl_pkg;

    localparam int REG_IDX_W           = 5;
    localparam int MEM_TIMEOUT_DEFAULT = 255;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } pipe_state_t;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Combinational load-use hazard compare between the EX load and the ID instruction.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_uses_rs2,
    input  logic                 ex_memread,
    input  logic [REG_IDX_W-1:0] ex_rd,
    output logic                 load_use
);

    // x0 is hardwired to zero, so a load targeting it never creates a dependency
    assign load_use = ex_memread && (ex_rd != '0) &&
                      ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencing controller: load-use bubble, branch squash, memory freeze and timeout.
// Optional performance counters are enabled by defining PIPE_PERF_CNT_EN.
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT,
    parameter int WAIT_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_uses_rs2,
    input  logic                 ex_memread,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 ex_branch_taken,
    input  logic                 mem_req,
    input  logic                 dmem_ready,
    output logic                 pc_we,
    output logic                 ifid_we,
    output logic                 idex_we,
    output logic                 exmem_we,
    output logic                 ifid_flush,
    output logic                 idex_flush,
    output logic                 memwb_bubble,
`ifdef PIPE_PERF_CNT_EN
    output logic [31:0]          stall_cycles,
    output logic [31:0]          flush_events,
`endif
    output logic                 mem_err
);

    pipe_state_t       state, state_next;
    logic [WAIT_W-1:0] wait_cnt, wait_next;
    logic              load_use;
    logic              normal, freeze;

    hazard_detect u_hazard_detect (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs2 (id_uses_rs2),
        .ex_memread  (ex_memread),
        .ex_rd       (ex_rd),
        .load_use    (load_use)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_next;
        end
    end

    always_comb begin
        state_next   = state;
        wait_next    = wait_cnt;
        normal       = 1'b0;
        freeze       = 1'b0;
        pc_we        = 1'b0;
        ifid_we      = 1'b0;
        idex_we      = 1'b0;
        exmem_we     = 1'b0;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        memwb_bubble = 1'b0;
        mem_err      = 1'b0;

        case (state)
            RUN: begin
                if (mem_req && !dmem_ready) begin
                    freeze     = 1'b1;
                    wait_next  = WAIT_W'(1);
                    state_next = MEM_WAIT;
                end else begin
                    normal = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    normal     = 1'b1;
                    wait_next  = '0;
                    state_next = RUN;
                end else begin
                    freeze = 1'b1;
                    if (wait_cnt == WAIT_W'(MEM_TIMEOUT))
                        state_next = ERROR;
                    else
                        wait_next = wait_cnt + WAIT_W'(1);
                end
            end
            ERROR: begin
                memwb_bubble = 1'b1;
                mem_err      = 1'b1;
            end
            default: state_next = RUN;
        endcase

        // A taken branch squashes the stalled instruction, so it outranks load-use
        if (normal) begin
            pc_we    = 1'b1;
            ifid_we  = 1'b1;
            idex_we  = 1'b1;
            exmem_we = 1'b1;
            if (ex_branch_taken) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (load_use) begin
                pc_we      = 1'b0;
                ifid_we    = 1'b0;
                idex_flush = 1'b1;
            end
        end
        if (freeze)
            memwb_bubble = 1'b1;

        if (rst) begin
            pc_we        = 1'b0;
            ifid_we      = 1'b0;
            idex_we      = 1'b0;
            exmem_we     = 1'b0;
            ifid_flush   = 1'b0;
            idex_flush   = 1'b0;
            memwb_bubble = 1'b0;
            mem_err      = 1'b0;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (!pc_we && state != ERROR)
                stall_cycles <= stall_cycles + 32'd1;
            if (ifid_flush)
                flush_events <= flush_events + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl (MEM_TIMEOUT=4); counter checks under PIPE_PERF_CNT_EN.
module tb_pipeline_ctrl;

    localparam logic [7:0] O_OFF    = 8'h00;
    localparam logic [7:0] O_NORMAL = 8'hF0;
    localparam logic [7:0] O_LDUSE  = 8'h34;
    localparam logic [7:0] O_BRANCH = 8'hFC;
    localparam logic [7:0] O_FREEZE = 8'h02;
    localparam logic [7:0] O_ERROR  = 8'h03;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic       id_uses_rs2 = 1'b0, ex_memread = 1'b0, ex_branch_taken = 1'b0;
    logic       mem_req = 1'b0, dmem_ready = 1'b0;
    logic       pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_flush, memwb_bubble, mem_err;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cycles, flush_events;
`endif
    logic [7:0] outs;

    int n_cmp  = 0;
    int n_fail = 0;

    assign outs = {pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_flush, memwb_bubble, mem_err};

    always #5 clk = ~clk;

    pipeline_ctrl #(.MEM_TIMEOUT(4), .WAIT_W(8)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_uses_rs2     (id_uses_rs2),
        .ex_memread      (ex_memread),
        .ex_rd           (ex_rd),
        .ex_branch_taken (ex_branch_taken),
        .mem_req         (mem_req),
        .dmem_ready      (dmem_ready),
        .pc_we           (pc_we),
        .ifid_we         (ifid_we),
        .idex_we         (idex_we),
        .exmem_we        (exmem_we),
        .ifid_flush      (ifid_flush),
        .idex_flush      (idex_flush),
        .memwb_bubble    (memwb_bubble),
`ifdef PIPE_PERF_CNT_EN
        .stall_cycles    (stall_cycles),
        .flush_events    (flush_events),
`endif
        .mem_err         (mem_err)
    );

    task automatic idle_inputs();
        id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        id_uses_rs2 = 1'b0; ex_memread = 1'b0; ex_branch_taken = 1'b0;
        mem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        mem_req = 1'b1;
        #1;
        n_cmp++;
        if (outs !== O_OFF) begin
            n_fail++;
            $display("FAIL reset_outs: got %h expected %h", outs, O_OFF);
        end
        @(negedge clk);
        rst = 1'b0;
        mem_req = 1'b0;
        #1;
        n_cmp++;
        if (outs !== O_NORMAL) begin
            n_fail++;
            $display("FAIL reset_release_normal: got %h expected %h", outs, O_NORMAL);
        end
    endtask

    task automatic test_load_use();
        @(negedge clk);
        ex_memread = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5;
        #1;
        n_cmp++;
        if (outs !== O_LDUSE) begin
            n_fail++;
            $display("FAIL load_use_rs1: got %h expected %h", outs, O_LDUSE);
        end
        @(negedge clk);
        ex_memread = 1'b0;
        #1;
        n_cmp++;
        if (outs !== O_NORMAL) begin
            n_fail++;
            $display("FAIL load_use_cleared: got %h expected %h", outs, O_NORMAL);
        end
        @(negedge clk);
        ex_memread = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0;
        #1;
        n_cmp++;
        if (outs !== O_NORMAL) begin
            n_fail++;
            $display("FAIL load_use_x0: got %h expected %h", outs, O_NORMAL);
        end
        @(negedge clk);
        ex_rd = 5'd9; id_rs1 = 5'd3; id_rs2 = 5'd9; id_uses_rs2 = 1'b1;
        #1;
        n_cmp++;
        if (outs !== O_LDUSE) begin
            n_fail++;
            $display("FAIL load_use_rs2: got %h expected %h", outs, O_LDUSE);
        end
        @(negedge clk);
        id_uses_rs2 = 1'b0;
        #1;
        n_cmp++;
        if (outs !== O_NORMAL) begin
            n_fail++;
            $display("FAIL load_use_rs2_unused: got %h expected %h", outs, O_NORMAL);
        end
        @(negedge clk);
        ex_memread = 1'b0; ex_rd = 5'd5; id_rs1 = 5'd5;
        #1;
        n_cmp++;
        if (outs !== O_NORMAL) begin
            n_fail++;
            $display("FAIL no_load_no_stall: got %h expected %h", outs, O_NORMAL);
        end
        idle_inputs();
    endtask

    task automatic test_branch();
        @(negedge clk);
        ex_memread = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; ex_branch_taken = 1'b1;
        #1;
        n_cmp++;
        if (outs !== O_BRANCH) begin
            n_fail++;
            $display("FAIL branch_over_load_use: got %h expected %h", outs, O_BRANCH);
        end
        @(negedge clk);
        ex_memread = 1'b0;
        #1;
        n_cmp++;
        if (outs !== O_BRANCH) begin
            n_fail++;
            $display("FAIL branch_alone: got %h expected %h", outs, O_BRANCH);
        end
        idle_inputs();
    endtask

    task automatic test_mem_wait();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mem_req = 1'b1; dmem_ready = 1'b0;
            #1;
            n_cmp++;
            if (outs !== O_FREEZE) begin
                n_fail++;
                $display("FAIL mem_freeze[%0d]: got %h expected %h", i, outs, O_FREEZE);
            end
        end
        @(negedge clk);
        dmem_ready = 1'b1;
        #1;
        n_cmp++;
        if (outs !== O_NORMAL) begin
            n_fail++;
            $display("FAIL mem_release: got %h expected %h", outs, O_NORMAL);
        end
        @(negedge clk);
        mem_req = 1'b0; dmem_ready = 1'b0;
        #1;
        n_cmp++;
        if (outs !== O_NORMAL) begin
            n_fail++;
            $display("FAIL mem_back_to_run: got %h expected %h", outs, O_NORMAL);
        end
        @(negedge clk);
        mem_req = 1'b1; dmem_ready = 1'b1;
        #1;
        n_cmp++;
        if (outs !== O_NORMAL) begin
            n_fail++;
            $display("FAIL mem_ready_first: got %h expected %h", outs, O_NORMAL);
        end
        @(negedge clk);
        dmem_ready = 1'b0;
        #1;
        n_cmp++;
        if (outs !== O_FREEZE) begin
            n_fail++;
            $display("FAIL mem_freeze_again: got %h expected %h", outs, O_FREEZE);
        end
        @(negedge clk);
        dmem_ready = 1'b1; ex_memread = 1'b1; ex_rd = 5'd4; id_rs1 = 5'd4;
        #1;
        n_cmp++;
        if (outs !== O_LDUSE) begin
            n_fail++;
            $display("FAIL mem_release_load_use: got %h expected %h", outs, O_LDUSE);
        end
        idle_inputs();
    endtask

    task automatic test_timeout();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            mem_req = 1'b1; dmem_ready = 1'b0;
            #1;
            n_cmp++;
            if (outs !== O_FREEZE) begin
                n_fail++;
                $display("FAIL timeout_freeze[%0d]: got %h expected %h", i, outs, O_FREEZE);
            end
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i > 0) begin
                mem_req = 1'b0; dmem_ready = 1'b1;
            end
            #1;
            n_cmp++;
            if (outs !== O_ERROR) begin
                n_fail++;
                $display("FAIL timeout_error[%0d]: got %h expected %h", i, outs, O_ERROR);
            end
        end
        do_reset();
        #1;
        n_cmp++;
        if (outs !== O_NORMAL) begin
            n_fail++;
            $display("FAIL error_cleared_by_rst: got %h expected %h", outs, O_NORMAL);
        end
    endtask

    task automatic test_reset_mid_wait();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mem_req = 1'b1; dmem_ready = 1'b0;
        end
        #1;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (outs !== O_OFF) begin
            n_fail++;
            $display("FAIL rst_mid_wait_outs: got %h expected %h", outs, O_OFF);
        end
`ifdef PIPE_PERF_CNT_EN
        n_cmp++;
        if (stall_cycles !== 32'd0 || flush_events !== 32'd0) begin
            n_fail++;
            $display("FAIL rst_counters: got %0d/%0d expected 0/0", stall_cycles, flush_events);
        end
`endif
        @(negedge clk);
        rst = 1'b0;
        mem_req = 1'b0;
        #1;
        n_cmp++;
        if (outs !== O_NORMAL) begin
            n_fail++;
            $display("FAIL rst_mid_wait_run: got %h expected %h", outs, O_NORMAL);
        end
        // a cleared wait counter allows the full five frozen cycles again
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            mem_req = 1'b1;
            #1;
            n_cmp++;
            if (outs !== O_FREEZE) begin
                n_fail++;
                $display("FAIL rst_wait_cnt_freeze[%0d]: got %h expected %h", i, outs, O_FREEZE);
            end
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (outs !== O_ERROR) begin
            n_fail++;
            $display("FAIL rst_wait_cnt_error: got %h expected %h", outs, O_ERROR);
        end
        do_reset();
    endtask

`ifdef PIPE_PERF_CNT_EN
    task automatic test_perf_counters();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            ex_memread = 1'b1; ex_rd = 5'd6; id_rs1 = 5'd6;
            @(negedge clk);
            idle_inputs();
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            ex_branch_taken = 1'b1;
            @(negedge clk);
            idle_inputs();
        end
        @(negedge clk);
        n_cmp++;
        if (stall_cycles !== 32'd3) begin
            n_fail++;
            $display("FAIL perf_stall_cycles: got %0d expected 3", stall_cycles);
        end
        n_cmp++;
        if (flush_events !== 32'd2) begin
            n_fail++;
            $display("FAIL perf_flush_events: got %0d expected 2", flush_events);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        do_reset();
        test_timeout();
        test_reset_mid_wait();
`ifdef PIPE_PERF_CNT_EN
        test_perf_counters();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
